// File: rtl/mem_pkg.sv
// Shared widths, address map and FSM encoding for the memory responder.
package mem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 10;

    localparam logic [ADDR_W-1:0] PROG_BASE = 14'h2000;
    localparam logic [ADDR_W-1:0] PROG_LAST = 14'h3FFF;

    // LOAD holds the CPU in reset while the loader fills the program region;
    // RUN hands the memory to the CPU until the next reset.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The program region is the upper half of the address space.
    function automatic logic is_prog(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1];
    endfunction

endpackage

// File: rtl/mem_array.sv
// 16K x 10 storage: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset so a reload only touches what it writes.
module mem_array
    import mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Write port: commits on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Program loader plus CPU memory port. After reset the loader streams words
// into the program region while the CPU is held in reset; the final word (or
// running off the end of the region) releases the CPU, which then owns the
// memory with the program region write-protected.
//
// Loader handshake: a word is transferred in every cycle where ld_valid and
// ld_ready are both high at the rising edge; ld_last is only meaningful in a
// transfer cycle. ld_ready does not depend on ld_valid.
module mem_responder
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_indata,
    input  logic              m_write,
    input  logic              m_read,
    output logic [DATA_W-1:0] m_outdata,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_ovf,
    output logic              wp_err,
    output logic              rw_err,
    output logic              D_STATE,
    output logic [ADDR_W-1:0] D_LDADDR
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              ld_ovf_q, ld_ovf_d;
    logic              wp_err_q, wp_err_d;
    logic              rw_err_q, rw_err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // State, load pointer and sticky flags; reset restarts loading at PROG_BASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            ld_addr_q <= PROG_BASE;
            ld_ovf_q  <= 1'b0;
            wp_err_q  <= 1'b0;
            rw_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            ld_ovf_q  <= ld_ovf_d;
            wp_err_q  <= wp_err_d;
            rw_err_q  <= rw_err_d;
        end
    end

    // Next state, write-port mux (loader vs CPU) and handshake outputs.
    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        ld_ovf_d  = ld_ovf_q;
        wp_err_d  = wp_err_q;
        rw_err_d  = rw_err_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr_q;
        mem_wdata = ld_data;
        ld_ready  = 1'b0;
        cpu_hold  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                ld_ready = 1'b1;
                cpu_hold = 1'b1;
                if (ld_valid) begin
                    mem_we = 1'b1;
                    if (ld_addr_q == PROG_LAST) begin
                        // Region full: keep the pointer parked, release the CPU.
                        state_d = ST_RUN;
                        if (!ld_last) begin
                            ld_ovf_d = 1'b1;
                        end
                    end else begin
                        ld_addr_d = ld_addr_q + 14'd1;
                        if (ld_last) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (m_write) begin
                    if (is_prog(m_addr)) begin
                        wp_err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = m_addr;
                        mem_wdata = m_indata;
                    end
                end
                if (m_write && m_read) begin
                    rw_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    mem_array u_mem_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (m_addr),
        .rdata_o (mem_rdata)
    );

    // Read data is visible to the CPU only once it runs.
    assign m_outdata = (state_q == ST_RUN) ? mem_rdata : '0;

    assign ld_ovf   = ld_ovf_q;
    assign wp_err   = wp_err_q;
    assign rw_err   = rw_err_q;
    assign D_STATE  = (state_q == ST_RUN);
    assign D_LDADDR = ld_addr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: loader flow, CPU vectors, overflow and
// reset corner cases.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [13:0] m_addr;
  logic [9:0]  m_indata;
  logic        m_write;
  logic        m_read;
  logic [9:0]  m_outdata;
  logic        ld_valid;
  logic [9:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_hold;
  logic        ld_ovf;
  logic        wp_err;
  logic        rw_err;
  logic        D_STATE;
  logic [13:0] D_LDADDR;

  int checks = 0;
  int failures = 0;

  mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .m_addr    (m_addr),
    .m_indata  (m_indata),
    .m_write   (m_write),
    .m_read    (m_read),
    .m_outdata (m_outdata),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_hold  (cpu_hold),
    .ld_ovf    (ld_ovf),
    .wp_err    (wp_err),
    .rw_err    (rw_err),
    .D_STATE   (D_STATE),
    .D_LDADDR  (D_LDADDR)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        rd;
    logic [13:0] addr;
    logic [9:0]  data;
    logic        chk_out;
    logic [9:0]  exp_out;
    logic        exp_wp;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [9:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [13:0] a, input logic [9:0] exp);
    m_addr = a;
    #1;
    chk(name, 14'(m_outdata), 14'(exp));
  endtask

  // mid-cycle asynchronous reset pulse; called at posedge+1
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_state"},  14'(D_STATE), 14'd0);
    chk({tag, "_ldaddr"}, D_LDADDR, 14'h2000);
    chk({tag, "_ready"},  14'(ld_ready), 14'd1);
    chk({tag, "_hold"},   14'(cpu_hold), 14'd1);
    chk({tag, "_flags"},  14'({ld_ovf, wp_err, rw_err}), 14'd0);
    chk({tag, "_out"},    14'(m_outdata), 14'd0);
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 14'h0010, 10'h155, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 14'h0010, 10'h000, 1'b1, 10'h155, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 14'h2000, 10'h000, 1'b1, 10'h001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 14'h2001, 10'h000, 1'b1, 10'h002, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 14'h2002, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 14'h2001, 10'h2AA, 1'b1, 10'h002, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 14'h2001, 10'h000, 1'b1, 10'h002, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 14'h0020, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 14'h0020, 10'h0F0, 1'b1, 10'h000, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 14'h0020, 10'h000, 1'b1, 10'h0F0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 14'h0010, 10'h000, 1'b1, 10'h155, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 14'h1FFF, 10'h3FF, 1'b0, 10'h000, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 14'h1FFF, 10'h000, 1'b1, 10'h3FF, 1'b1, 1'b1};

    // reset
    rst = 1'b1;
    m_addr = '0; m_indata = '0; m_write = 1'b0; m_read = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #2;
    chk("rst_state",  14'(D_STATE), 14'd0);
    chk("rst_ldaddr", D_LDADDR, 14'h2000);
    chk("rst_ready",  14'(ld_ready), 14'd1);
    chk("rst_hold",   14'(cpu_hold), 14'd1);
    chk("rst_flags",  14'({ld_ovf, wp_err, rw_err}), 14'd0);
    chk("rst_out",    14'(m_outdata), 14'd0);
    #10 rst = 1'b0;
    step();

    // load 3 words while the CPU strobes are active (must be ignored)
    m_write = 1'b1; m_read = 1'b1; m_addr = 14'h0005; m_indata = 10'h111;
    #1 chk("load_out_zero", 14'(m_outdata), 14'd0);
    load_word(10'h001, 1'b0);
    chk("load1_hold", 14'(cpu_hold), 14'd1);
    chk("load1_addr", D_LDADDR, 14'h2001);
    load_word(10'h002, 1'b0);
    chk("load2_hold", 14'(cpu_hold), 14'd1);
    load_word(10'h3FF, 1'b1);
    chk("load3_hold",  14'(cpu_hold), 14'd0);
    chk("load3_ready", 14'(ld_ready), 14'd0);
    chk("load3_state", 14'(D_STATE), 14'd1);
    chk("load3_addr",  D_LDADDR, 14'h2003);
    chk("load3_flags", 14'({ld_ovf, wp_err, rw_err}), 14'd0);
    m_write = 1'b0; m_read = 1'b0;

    // RUN vectors; loader keeps presenting words that must be ignored
    for (int i = 0; i < 13; i++) begin
      ld_valid = 1'b1; ld_data = 10'h3AB; ld_last = 1'b1;
      m_write  = vecs[i].we;
      m_read   = vecs[i].rd;
      m_addr   = vecs[i].addr;
      m_indata = vecs[i].data;
      #1;
      if (vecs[i].chk_out) chk($sformatf("vec%0d_out", i), 14'(m_outdata), 14'(vecs[i].exp_out));
      step();
      chk($sformatf("vec%0d_wp", i),   14'(wp_err), 14'(vecs[i].exp_wp));
      chk($sformatf("vec%0d_rw", i),   14'(rw_err), 14'(vecs[i].exp_rw));
      chk($sformatf("vec%0d_hold", i), 14'(cpu_hold), 14'd0);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    m_write = 1'b0; m_read = 1'b0;
    chk("run_ldaddr_frozen", D_LDADDR, 14'h2003);
    chk("run_ovf", 14'(ld_ovf), 14'd0);

    // asynchronous reset from RUN, output address holds 0x155
    m_addr = 14'h0010;
    async_reset("rst_run");

    // overflow: 8192 words without ld_last
    for (int i = 0; i < 8192; i++) begin
      logic [13:0] iv;
      iv = 14'(i);
      ld_valid = 1'b1;
      ld_data  = iv[9:0];
      ld_last  = 1'b0;
      step();
      if (i == 8190) begin
        chk("ovf_pre_addr",  D_LDADDR, 14'h3FFF);
        chk("ovf_pre_state", 14'(D_STATE), 14'd0);
      end
    end
    ld_valid = 1'b0;
    chk("ovf_flag",  14'(ld_ovf), 14'd1);
    chk("ovf_state", 14'(D_STATE), 14'd1);
    chk("ovf_addr",  D_LDADDR, 14'h3FFF);
    chk("ovf_hold",  14'(cpu_hold), 14'd0);
    read_chk("ovf_rd_3fff", 14'h3FFF, 10'h3FF);
    read_chk("ovf_rd_2000", 14'h2000, 10'h000);
    read_chk("ovf_rd_2005", 14'h2005, 10'h005);
    read_chk("ovf_rd_0010", 14'h0010, 10'h155);
    step();

    // reset mid-load then reload
    async_reset("rst_ovf");
    for (int i = 0; i < 5; i++) begin
      logic [9:0] dv;
      dv = 10'h0A0 + 10'(i);
      load_word(dv, 1'b0);
    end
    chk("part_addr", D_LDADDR, 14'h2005);
    async_reset("rst_mid");
    load_word(10'h111, 1'b0);
    chk("reload1_hold", 14'(cpu_hold), 14'd1);
    chk("reload1_addr", D_LDADDR, 14'h2001);
    load_word(10'h222, 1'b1);
    chk("reload2_hold",  14'(cpu_hold), 14'd0);
    chk("reload2_addr",  D_LDADDR, 14'h2002);
    chk("reload2_flags", 14'({ld_ovf, wp_err, rw_err}), 14'd0);
    read_chk("reload_rd_2000", 14'h2000, 10'h111);
    read_chk("reload_rd_2001", 14'h2001, 10'h222);
    read_chk("reload_rd_2002", 14'h2002, 10'h0A2);
    read_chk("reload_rd_2005", 14'h2005, 10'h005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  in  1  system clock; same clock that drives the CPU.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 m_addr  in  14  CPU word address.
REQ-005 m_indata  in  10  CPU write data.
REQ-006 m_write  in  1  CPU write strobe; the write commits at the rising edge.
REQ-007 m_read  in  1  CPU read strobe.
REQ-008 m_outdata  out  10  read data, combinational from m_addr.
REQ-009 ld_valid  in  1  loader word valid.
REQ-010 ld_data  in  10  loader word.
REQ-011 ld_last  in  1  marks the final loader word; qualified by ld_valid.
REQ-012 ld_ready  out  1  loader may present a word.
REQ-013 cpu_hold  out  1  holds the CPU in reset; the CPU's rst SHALL be driven from rst OR cpu_hold.
REQ-014 ld_ovf  out  1  sticky flag: program region overflowed during load.
REQ-015 wp_err  out  1  sticky flag: CPU attempted a write into the program region.
REQ-016 rw_err  out  1  sticky flag: m_read and m_write were asserted in the same cycle.
REQ-017 D_STATE  out  1  debug: 0 = LOAD, 1 = RUN.
REQ-018 D_LDADDR  out  14  debug: current load address.

Function
REQ-019 Storage SHALL be 16384 x 10-bit words. The program region is addresses 0x2000-0x3FFF (m_addr[13]=1). The data region is 0x0000-0x1FFF.
REQ-020 The FSM SHALL have two states, LOAD and RUN. Reset enters LOAD; RUN is left only by reset.
REQ-021 In LOAD: ld_ready=1 and cpu_hold=1. A word is accepted in any cycle where ld_valid=1.
REQ-022 Each accepted word SHALL be written to mem[ld_addr], and ld_addr SHALL increment by 1. Throughput is one word per cycle.
REQ-023 An accepted word with ld_last=1 SHALL cause a transition to RUN at that edge. In the next cycle ld_ready=0 and cpu_hold=0.
REQ-024 An accepted word at ld_addr=0x3FFF with ld_last=0 SHALL still be written. It SHALL also set ld_ovf, force the transition to RUN, and leave ld_addr at 0x3FFF (no wrap).
REQ-025 In LOAD, m_outdata SHALL be 0, and m_write/m_read SHALL be ignored, including for error flags.
REQ-026 In RUN: m_outdata = mem[m_addr] combinationally, regardless of m_read. ld_valid SHALL be ignored.
REQ-027 In RUN, m_write=1 with m_addr[13]=0 SHALL write m_indata to mem[m_addr] at the edge.
REQ-028 In RUN, m_write=1 with m_addr[13]=1 SHALL NOT modify memory and SHALL set wp_err.
REQ-029 In RUN, m_read=1 and m_write=1 in the same cycle SHALL set rw_err. The write still obeys REQ-027/028. m_outdata in that cycle shows the pre-write value.
REQ-030 A read of an address in the cycle after a write to it SHALL return the new value.
REQ-031 Sticky flags SHALL clear only on reset.

Reset
REQ-032 On rst assertion, the following SHALL take effect immediately, regardless of clk: state=LOAD, ld_addr=0x2000, ld_ready=1, cpu_hold=1, ld_ovf=0, wp_err=0, rw_err=0, m_outdata=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset mid-load SHALL restart loading at 0x2000.

Structure
REQ-035 A shared package mem_pkg SHALL hold:
- ADDR_W=14, DATA_W=10;
- PROG_BASE=14'h2000, PROG_LAST=14'h3FFF;
- the LOAD/RUN state enum.
REQ-036 The storage SHALL be one sub-module, mem_array: 16384x10, one asynchronous read port and one synchronous write port. The write mux (loader vs CPU) SHALL sit in mem_responder.

Verification
REQ-037 Reset, then load 3 words 0x001, 0x002, 0x3FF with ld_last on the third -> mem[0x2000..0x2002] hold those words; cpu_hold falls the cycle after the third word; ld_ovf=0.
REQ-038 RUN: write 0x155 to 0x0010, then read 0x0010 -> m_outdata=0x155 the next cycle; wp_err=0.
REQ-039 RUN: write 0x2AA to 0x2001 -> mem[0x2001] still 0x002; wp_err=1 and stays 1.
REQ-040 RUN: m_read=m_write=1, addr 0x0020, old value 0x000, new value 0x0F0 -> m_outdata=0x000 that cycle and 0x0F0 the next; rw_err=1.
REQ-041 Stream 8192 words without ld_last -> the last word lands at 0x3FFF; ld_ovf=1; state=RUN; D_LDADDR=0x3FFF.
REQ-042 Assert rst after 5 loaded words, then reload 2 words -> they land at 0x2000/0x2001; all flags 0; cpu_hold=1 until the second word with ld_last is accepted.
